// File: rtl/rf_wb_sched_pkg.sv
// rf_wb_sched_pkg
//   Constants and types shared by the register-file write-back scheduler:
//   bus widths, register count, enable/zero constants, the starvation limit
//   and the grant-source encoding used by the arbiter.
package rf_wb_sched_pkg;

  localparam int RegAddrBus  = 5;   // register address width
  localparam int RegDataBus  = 32;  // register data width
  localparam int RegFilesNum = 32;  // number of architectural registers
  localparam int StarveMax   = 4;   // B waiting cycles before forced priority
  localparam int ScW         = 4;   // starvation counter width (limit 1..15)

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [RegDataBus-1:0] ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] ZeroAddr = '0;

  // Which requester owns the write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } gnt_e;

endpackage

// File: rtl/rf_wb_sched_pend_board.sv
// rf_wb_sched_pend_board (rf_pend_board)
//   Per-register pending scoreboard for outstanding long-latency results.
//   A reservation sets the bit of its destination, a B write-back grant
//   clears it; when both hit the same register on one edge the set wins.
//   Register 0 never becomes pending.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   set_valid, set_addr   reserve a destination register
//   clr_valid, clr_addr   release a destination on its B grant
//   chk1_addr, chk2_addr  lookup addresses
//   hazard1, hazard2      pending bit of each lookup address (combinational)
//   pend                  full scoreboard vector
module rf_wb_sched_pend_board
  import rf_wb_sched_pkg::*;
#(
  parameter int ADDR_W = RegAddrBus,
  parameter int NREG   = RegFilesNum
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] chk1_addr,
  input  logic [ADDR_W-1:0] chk2_addr,
  output logic              hazard1,
  output logic              hazard2,
  output logic [NREG-1:0]   pend
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pend_next;

  // Decode both requests into one-hot masks. Bit 0 is never decoded, which
  // keeps r0 permanently clear without a special case in the register.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      set_mask[i] = set_valid && (set_addr == ADDR_W'(i));
      clr_mask[i] = clr_valid && (clr_addr == ADDR_W'(i));
    end
  end

  // Clear first, then set: a same-edge reserve of the returning register
  // keeps it pending for the new producer.
  assign pend_next = (pend_q & ~clr_mask) | set_mask;

  // NOTE: the scoreboard is a plain flop vector, not a RAM, so it can and
  // must be reset; a stale pending bit after reset would stall ID forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_next;
    end
  end

  assign pend    = pend_q;
  assign hazard1 = pend_q[chk1_addr];
  assign hazard2 = pend_q[chk2_addr];

endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched
//   Write-back scheduler for the register file's single write port.
//   Arbitrates between the in-order WB stage (port A) and long-latency
//   returns (port B). A wins by default; B gets forced priority once it has
//   waited STARVE_MAX consecutive cycles. The winner is registered onto the
//   write port one cycle later. A pending scoreboard tracks reserved
//   long-latency destinations for the ID stall logic.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   a_valid/a_addr/a_data/a_ready pipeline WB request handshake
//   b_valid/b_addr/b_data/b_ready long-latency return handshake
//   rsv_valid, rsv_addr           reserve a long-latency destination
//   chk1_addr, chk2_addr          ID source operand addresses
//   hazard1, hazard2              source register is still pending
//   wrn, wrDataAddr, wrData       registered register-file write port
//   pend                          scoreboard vector
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int ADDR_W     = RegAddrBus,
  parameter int DATA_W     = RegDataBus,
  parameter int NREG       = RegFilesNum,
  parameter int STARVE_MAX = StarveMax
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] chk1_addr,
  input  logic [ADDR_W-1:0] chk2_addr,
  output logic              hazard1,
  output logic              hazard2,
  output logic              wrn,
  output logic [ADDR_W-1:0] wrDataAddr,
  output logic [DATA_W-1:0] wrData,
  output logic [NREG-1:0]   pend
);

  logic [ScW-1:0]    sc;
  logic              starve;
  gnt_e              gnt;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic              b_grant;
  logic              err_waw;

  // ---------------------------------------------------------------- arbiter
  assign starve  = (sc == ScW'(STARVE_MAX));
  assign a_ready = !starve;
  assign b_ready = starve || !a_valid;

  // The ready rules already make the two grants mutually exclusive; the
  // priority order here only selects which payload drives the port.
  always_comb begin
    gnt    = GNT_NONE;
    g_addr = '0;
    g_data = '0;
    if (a_valid && a_ready) begin
      gnt    = GNT_A;
      g_addr = a_addr;
      g_data = a_data;
    end else if (b_valid && b_ready) begin
      gnt    = GNT_B;
      g_addr = b_addr;
      g_data = b_data;
    end
  end

  assign b_grant = (gnt == GNT_B);

  // Starvation counter: counts consecutive cycles B is presented but held
  // off, saturating at the limit that forces its grant.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc <= '0;
    end else if (b_grant || !b_valid) begin
      sc <= '0;
    end else if (!starve) begin
      sc <= sc + ScW'(1);
    end
  end

  // ---------------------------------------------------------- write port
  // A grant to r0 completes its handshake but never raises the enable.
  // Address/data only load on a grant; they are don't-care while wrn is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrn        <= WriteDisable;
      wrDataAddr <= '0;
      wrData     <= '0;
    end else begin
      wrn <= (gnt != GNT_NONE) && (g_addr != '0) ? WriteEnable : WriteDisable;
      if (gnt != GNT_NONE) begin
        wrDataAddr <= g_addr;
        wrData     <= g_data;
      end
    end
  end

  // ----------------------------------------------------------- scoreboard
  rf_wb_sched_pend_board #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_pend_board (
    .clk       (clk),
    .rst_n     (rst),
    .set_valid (rsv_valid),
    .set_addr  (rsv_addr),
    .clr_valid (b_grant),
    .clr_addr  (b_addr),
    .chk1_addr (chk1_addr),
    .chk2_addr (chk2_addr),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .pend      (pend)
  );

  // ------------------------------------------------------ WAW detection
  // An in-order write landing on a register that still awaits a long-latency
  // result means ID failed to stall. The write still commits; this sticky
  // flag only exists to be caught by the assertion below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_waw <= 1'b0;
    end else if ((gnt == GNT_A) && pend[a_addr]) begin
      err_waw <= 1'b1;
    end
  end

  a_no_waw : assert property (@(posedge clk) disable iff (!rst) !err_waw)
    else $error("rf_wb_sched: write-after-write to a pending register");

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched
//   Directed bench for rf_wb_sched. A behavioural model (wait counter,
//   pending array, expected write-port contents) is compared against the
//   DUT on every falling edge; directed sections add literal expectations.
module tb_rf_wb_sched;
  import rf_wb_sched_pkg::*;

  localparam int AW = RegAddrBus;
  localparam int DW = RegDataBus;
  localparam int NR = RegFilesNum;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready;
  logic          rsv_valid = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic [AW-1:0] chk1_addr = '0;
  logic [AW-1:0] chk2_addr = '0;
  logic          hazard1, hazard2;
  logic          wrn;
  logic [AW-1:0] wrDataAddr;
  logic [DW-1:0] wrData;
  logic [NR-1:0] pend;

  int n_vec  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  rf_wb_sched #(
    .ADDR_W(AW), .DATA_W(DW), .NREG(NR), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk1_addr(chk1_addr), .chk2_addr(chk2_addr),
    .hazard1(hazard1), .hazard2(hazard2),
    .wrn(wrn), .wrDataAddr(wrDataAddr), .wrData(wrData), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  // m_wait: how many consecutive cycles B has been presented and refused.
  int            m_wait = 0;
  bit            m_pend [NR];
  bit            m_wrn = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wait <= 0;
      for (int i = 0; i < NR; i++) m_pend[i] <= 1'b0;
      m_wrn  <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
    end else begin
      automatic bit forced  = (m_wait >= SM);
      automatic bit a_taken = a_valid && !forced;
      automatic bit b_taken = b_valid && (forced || !a_valid);
      if (a_taken) begin
        m_wrn <= (a_addr != 0); m_addr <= a_addr; m_data <= a_data;
      end else if (b_taken) begin
        m_wrn <= (b_addr != 0); m_addr <= b_addr; m_data <= b_data;
      end else begin
        m_wrn <= 1'b0;
      end
      if (b_taken || !b_valid) m_wait <= 0;
      else if (m_wait < SM)    m_wait <= m_wait + 1;
      if (b_taken) m_pend[b_addr] <= 1'b0;
      if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      automatic logic [NR-1:0] ep = '0;
      automatic bit forced = (m_wait >= SM);
      for (int i = 0; i < NR; i++) ep[i] = m_pend[i];
      check("cmp a_ready", 64'(a_ready), 64'(!forced));
      check("cmp b_ready", 64'(b_ready), 64'(forced || !a_valid));
      check("cmp hazard1", 64'(hazard1), 64'(m_pend[chk1_addr]));
      check("cmp hazard2", 64'(hazard2), 64'(m_pend[chk2_addr]));
      check("cmp pend",    64'(pend),    64'(ep));
      check("cmp wrn",     64'(wrn),     64'(m_wrn));
      if (m_wrn || !rst) begin
        check("cmp wrDataAddr", 64'(wrDataAddr), 64'(m_addr));
        check("cmp wrData",     64'(wrData),     64'(m_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------- stimulus
  initial begin
    logic [4:0] ar, br;
    logic       hs_a, hs_b;

    #1 rst = 1'b0;
    cmp_en = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset in the middle of traffic with B pending and r6 reserved.
    a_valid = 1; a_addr = 5'd2; a_data = 32'h22;
    b_valid = 1; b_addr = 5'd4; b_data = 32'h44;
    rsv_valid = 1; rsv_addr = 5'd6; chk1_addr = 5'd6;
    tick();
    rsv_valid = 0;
    tick();
    check("pre-reset wrn", 64'(wrn), 64'(1));
    check("pre-reset pend", 64'(pend), 64'h40);
    #2 rst = 1'b0;
    #1;
    check("reset wrn", 64'(wrn), 64'(0));
    check("reset wrDataAddr", 64'(wrDataAddr), 64'(0));
    check("reset wrData", 64'(wrData), 64'(0));
    check("reset pend", 64'(pend), 64'(0));
    check("reset hazard1", 64'(hazard1), 64'(0));
    check("reset a_ready", 64'(a_ready), 64'(1));
    a_valid = 0; b_valid = 0;
    tick();
    rst = 1'b1;
    a_valid = 1; a_addr = 5'd3; a_data = 32'h11;
    #1 check("post-reset a_ready", 64'(a_ready), 64'(1));
    tick();
    a_valid = 0;
    #1;
    check("post-reset wrn", 64'(wrn), 64'(1));
    check("post-reset wrDataAddr", 64'(wrDataAddr), 64'(3));
    check("post-reset wrData", 64'(wrData), 64'(32'h11));
    tick();

    // Continuous A with B r7 waiting: A wins 4 cycles, B on the 5th.
    a_valid = 1; b_valid = 1; b_addr = 5'd7; b_data = 32'hBEEF;
    for (int k = 0; k < 6; k++) begin
      a_addr = 5'(10 + k); a_data = 32'(k);
      #1;
      ar[k % 5] = a_ready;
      if (k < 5) br[k] = b_ready;
      hs_b = b_valid && b_ready;
      tick();
      if (hs_b) b_valid = 0;
      if (k == 4) begin
        #1;
        check("starve B wrn", 64'(wrn), 64'(1));
        check("starve B wrDataAddr", 64'(wrDataAddr), 64'(7));
        check("starve B wrData", 64'(wrData), 64'(32'hBEEF));
      end
    end
    check("starve a_ready seq", 64'(ar), 64'(5'b0_1111));
    check("starve b_ready seq", 64'(br), 64'(5'b1_0000));
    a_valid = 0;
    tick();

    // Scoreboard: reserve r9, then B returns r9.
    rsv_valid = 1; rsv_addr = 5'd9; chk1_addr = 5'd9; chk2_addr = 5'd1;
    #1 check("rsv r9 hazard1 before", 64'(hazard1), 64'(0));
    tick();
    rsv_valid = 0;
    #1 check("rsv r9 hazard1 after", 64'(hazard1), 64'(1));
    tick();
    b_valid = 1; b_addr = 5'd9; b_data = 32'h99;
    #1 check("ret r9 b_ready", 64'(b_ready), 64'(1));
    tick();
    b_valid = 0;
    #1;
    check("ret r9 hazard1", 64'(hazard1), 64'(0));
    check("ret r9 wrn", 64'(wrn), 64'(1));
    check("ret r9 wrDataAddr", 64'(wrDataAddr), 64'(9));

    // Set/clear collision on r5.
    rsv_valid = 1; rsv_addr = 5'd5; chk2_addr = 5'd5;
    tick();
    b_valid = 1; b_addr = 5'd5; b_data = 32'h55;
    tick();
    rsv_valid = 0; b_valid = 0;
    #1;
    check("collide pend[5]", 64'(pend[5]), 64'(1));
    check("collide hazard2", 64'(hazard2), 64'(1));

    // r0 handling.
    a_valid = 1; a_addr = 5'd0; a_data = 32'hFFFF;
    #1 check("r0 a_ready", 64'(a_ready), 64'(1));
    tick();
    a_valid = 0;
    rsv_valid = 1; rsv_addr = 5'd0; chk1_addr = 5'd0;
    #1 check("r0 wrn", 64'(wrn), 64'(0));
    tick();
    rsv_valid = 0;
    #1;
    check("r0 pend[0]", 64'(pend[0]), 64'(0));
    check("r0 hazard1", 64'(hazard1), 64'(0));

    // B alone.
    b_valid = 1; b_addr = 5'd12; b_data = 32'h1234;
    #1 check("B alone b_ready", 64'(b_ready), 64'(1));
    tick();
    b_valid = 0;
    #1;
    check("B alone wrn", 64'(wrn), 64'(1));
    check("B alone wrDataAddr", 64'(wrDataAddr), 64'(12));
    check("B alone wrData", 64'(wrData), 64'(32'h1234));
    tick();

    // Mixed traffic; A never targets reserved registers, valids hold until accepted.
    for (int c = 0; c < 60; c++) begin
      if (!a_valid) begin
        automatic int idx = int'($urandom_range(0, 6));
        a_valid = 1'($urandom_range(0, 1));
        a_addr  = (idx == 0) ? 5'd0 : 5'(idx + 9);
        a_data  = $urandom;
      end
      if (!b_valid) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = 5'(20 + $urandom_range(0, 3));
        b_data  = $urandom;
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = 5'(20 + $urandom_range(0, 3));
      chk1_addr = 5'($urandom_range(18, 25));
      chk2_addr = 5'($urandom_range(18, 25));
      #1;
      hs_a = a_valid && a_ready;
      hs_b = b_valid && b_ready;
      tick();
      if (hs_a) a_valid = 0;
      if (hs_b) b_valid = 0;
    end
    a_valid = 0; b_valid = 0; rsv_valid = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-back scheduler for the register file's single write port. It arbitrates between the in-order pipeline WB stage (port A) and the long-latency result return (port B: divider / load-miss). It drives one registered write per cycle into the register file and keeps a per-register pending scoreboard that ID uses to stall on outstanding long-latency destinations. It sits between MEM/WB and the register file, beside the ID-stage read logic.

## Interface
- `ADDR_W`, 5: register address width (`RegAddrBus`).
- `DATA_W`, 32: register data width (`RegDataBus`).
- `NREG`, 32: register count (`RegFilesNum`).
- `STARVE_MAX`, 4: consecutive B-waiting cycles before B takes forced priority; range 1..15.

- `clk` in 1: single clock; all state on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `a_valid` in 1, `a_addr` in ADDR_W, `a_data` in DATA_W: pipeline WB write request.
- `a_ready` out 1: A accepted this cycle when `a_valid && a_ready`.
- `b_valid` in 1, `b_addr` in ADDR_W, `b_data` in DATA_W: long-latency result.
- `b_ready` out 1: B accepted this cycle when `b_valid && b_ready`.
- `rsv_valid` in 1, `rsv_addr` in ADDR_W: ID dispatches a long-latency op; reserve destination.
- `chk1_addr`, `chk2_addr` in ADDR_W: ID rs/rt addresses.
- `hazard1`, `hazard2` out 1: combinational; pending bit of `chk1_addr`/`chk2_addr` is set.
- `wrn` out 1, `wrDataAddr` out ADDR_W, `wrData` out DATA_W: registered write port to the register file.
- `pend` out NREG: scoreboard vector, bit i = register i is reserved.

## Operation
- Starvation counter `sc` (4 bit): increments, saturating at STARVE_MAX, each cycle `b_valid && !b_ready`. It clears on a B grant or when `b_valid` is low.
- Forced mode `starve = (sc == STARVE_MAX)`.
- Ready rules:
  - `a_ready = !starve`.
  - `b_ready = starve || !a_valid`.
  - Requesters must not make valid depend on ready. Data must hold while valid and not ready.
- At most one grant per cycle. A normally wins; B wins when `starve`.
- The grant registers `{wrn, wrDataAddr, wrData}` on the next edge. `wrn = 1` only if a grant occurred and the granted address ≠ 0. A write to r0 is accepted (handshake completes) and dropped.
- Scoreboard `pend[NREG-1:0]`:
  - Set on `rsv_valid` with `rsv_addr ≠ 0`.
  - Cleared on the edge that accepts a B grant for that address.
  - Same address reserved and cleared in the same cycle: set wins.
  - `pend[0]` is always 0.
- `hazard1 = pend[chk1_addr]` and `hazard2 = pend[chk2_addr]`, purely combinational from state.
  - Operand forwarding of the write in flight is the register file's own same-cycle bypass; this block adds none.
- A grant to an address whose pending bit is set (WAW, an ID-stall violation) still commits. The sticky `err_waw` bit is simulation-only, checked by assertion, and not a port.

## Timing
- Latency: handshake at edge N → `wrn`/`wrDataAddr`/`wrData` valid in cycle N+1, committed by the register file at edge N+2.
- `pend` clears at edge N. `hazard*` drops in cycle N+1, the same cycle the data is on the write port and visible through the register file bypass.
- Reserve at edge N → `hazard*` high from cycle N+1.
- Under continuous A traffic, B waits exactly STARVE_MAX cycles, is granted on the next, then the counter restarts. Worst-case A throughput loss: 1 in STARVE_MAX+1.
- Reset (asynchronous assert, any cycle, including mid-burst or with B pending):
  - `wrn=0`, `wrDataAddr=0`, `wrData=0`, `pend=0`, `sc=0`, `hazard*=0`.
  - Ready outputs evaluate with `sc=0`.
  - Outstanding requests are not remembered; requesters re-present after reset.
- Deassertion takes effect at the first posedge after `rst` rises.

## Structure
- Address/data widths, `RegFilesNum`, and enable/zero constants come from the shared defines file. Add `StarveMax` there.
- One natural sub-module: `rf_pend_board`. It holds the NREG-bit scoreboard with set/clear/lookup logic (two lookup ports). The arbiter, starvation counter and output register stay in the top.

## Test plan
- Reset mid-traffic: `rst=0` while `a_valid` and B pending → all outputs 0 immediately, `pend=0`. After release, `a_addr=3, a_data=0x11` → `wrn=1, wrDataAddr=3, wrData=0x11` one cycle after handshake.
- Simultaneous A/B, `STARVE_MAX=4`: A valid every cycle, B valid (addr 7, 0xBEEF) → A granted 4 cycles, B granted on the 5th, `a_ready=0` that cycle; B write appears the following cycle.
- Scoreboard: reserve r9 → `hazard1=1` for `chk1_addr=9` next cycle. B returns r9 → `hazard1` falls in the cycle `wrDataAddr=9, wrn=1`.
- Set/clear collision: B grant to r5 and `rsv_valid` r5 in the same cycle → `pend[5]` stays 1.
- r0 handling: A write addr 0 data 0xFFFF → `a_ready=1`, `wrn` stays 0. Reserve r0 → `pend[0]=0`, `hazard` low.
- B alone: `a_valid=0`, B r12 0x1234 → `b_ready=1` same cycle, write next cycle, `sc` stays 0.
